uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of the team's 8N1 transmitter on the same board clock. It samples an asynchronous `rx` line and recovers 8-bit frames: one start bit, 8 data bits LSB first, and one stop bit. Completed bytes are delivered through a one-entry holding register with a valid/ready handshake. Framing and overrun errors are flagged; a parity check can optionally be compiled in.

## Interface
- `FREQ`, 12000000, system clock frequency in Hz.
- `BAUD`, 9600, line bit rate.
- `CLKS_PER_BIT`, FREQ/BAUD (1250), clocks per bit period.
- `HALF`, (CLKS_PER_BIT-1)/2 (624), start-bit mid-point offset.
- `clk  in  1  system clock, rising edge`
- `nrst  in  1  reset, asynchronous, active-low`
- `rx  in  1  asynchronous serial input, idle high`
- `rx_ready  in  1  consumer accepts byte this cycle`
- `rx_data  out  8  received byte, stable while rx_valid`
- `rx_valid  out  1  holding register full`
- `rx_busy  out  1  frame in progress (state != IDLE)`
- `frame_err  out  1  one-cycle pulse, stop bit sampled low`
- `overrun  out  1  one-cycle pulse, byte dropped because holding register full`
- `parity_err  out  1  one-cycle pulse, parity mismatch (0 when parity compiled out)`

## Operation
- `rx` passes through a 2-flop synchronizer reset to 1. Edge detection uses the synchronized value and one further registered copy.
- FSM states: IDLE, START, DATA, PARITY (compiled with macro only), STOP.
- IDLE: a falling edge (prev=1, cur=0) loads `baud_cnt`=0 and moves to START. A line held low never retriggers.
- START: when `baud_cnt`==HALF, sample the line. If 0, clear `baud_cnt` and `bit_idx`, go to DATA. If 1, treat as a glitch and return to IDLE with no flag.
- DATA: when `baud_cnt`==CLKS_PER_BIT-1, sample and shift into `shreg` from the MSB (`shreg <= {rx_s, shreg[7:1]}`), then increment `bit_idx`. After bit 7, go to PARITY or STOP.
- PARITY: sample one bit period later and compare with XOR of `shreg` (even parity). On mismatch, set the internal `par_bad` flag.
- STOP: sample one bit period later, then return to IDLE.
  - Sample 1 and no `par_bad`: the byte is delivered.
  - Sample 0: `frame_err` pulses and the byte is discarded.
  - `par_bad` set: `parity_err` pulses and the byte is discarded.
- Delivery rules:
  - Holding register empty, or `rx_valid && rx_ready` in the same cycle: load `rx_data`, and `rx_valid`=1.
  - Otherwise: `overrun` pulses, the old byte is kept, and the new byte is dropped.
- Consume: `rx_valid && rx_ready` clears `rx_valid` next cycle unless a delivery happens in the same cycle.
- `baud_cnt` is `$clog2(CLKS_PER_BIT)` bits (11 at defaults). It resets to 0 on every sample and never wraps.
- Reset mid-frame: FSM returns to IDLE, and any partial byte and pending holding-register content are lost.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0, `parity_err`=0. The synchronizer flops reset to 1.
- Input latency: 2 clocks from `rx` pin to synchronized value. The falling edge is detected on the third clock.
- Stop sample occurs at HALF + 9·CLKS_PER_BIT clocks after detection (+CLKS_PER_BIT with parity).
- `rx_valid`, `frame_err`, `parity_err` and `overrun` update on the clock after the stop sample. Error flags are high for exactly one clock.
- `rx_busy` rises the clock after edge detection and falls on the clock after the stop sample.
- Back-to-back frames: IDLE is re-entered at mid-stop bit, so the next start edge one half bit later is caught.
- Tolerance: ±4% baud mismatch still samples inside each bit.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists and the frame is 11 bits (start, 8 data, even parity, stop). `parity_err` is active.
- Not defined: 8N1 frame and no PARITY state. `parity_err` is tied 0.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), default FREQ/BAUD constants, and frame length constants shared with the transmitter.
- Sub-module `uart_sync2`: reset-to-1 two-flop synchronizer, reusable for other async inputs.

## Test plan
- Send 8N1 frame 0x61 with `rx_ready`=1 → `rx_valid` pulses once with `rx_data`=0x61, at HALF+9·1250+1 clocks after the edge; no error flags.
- Send back-to-back 0x6E, 0x53, 0x70 with no idle gap and `rx_ready` held 1 → three valids in order, no overrun.
- Drive a 300-clock low glitch → START aborts, `rx_busy` returns to 0, no valid and no flags.
- Send 0x61 with the stop bit forced 0 → `frame_err` 1-clock pulse, `rx_valid` stays 0; a following 0x53 is received correctly once the line returns high.
- Send 0x61 then 0x53 with `rx_ready`=0 → `overrun` pulses once, `rx_data` stays 0x61; raising `rx_ready` clears `rx_valid`.
- With `UART_RX_PARITY_EN`, send 0x61 with parity bit 0 (expected 1) → `parity_err` pulse, no valid. In a separate run, assert `nrst` mid-data → all outputs reset, and the next frame 0x70 is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and frame
// lengths used by both the receiver and the 8N1 transmitter.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam int unsigned FREQ_DEFAULT = 12000000;
  localparam int unsigned BAUD_DEFAULT = 9600;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned FRAME_BITS_8N1 = 10;
  localparam int unsigned FRAME_BITS_8E1 = 11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input that idles high; both flops
// reset to 1 so an idle line never looks like an edge coming out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1) with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and flag parity errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ         = FREQ_DEFAULT,
  parameter int unsigned BAUD         = BAUD_DEFAULT,
  parameter int unsigned CLKS_PER_BIT = FREQ / BAUD,
  parameter int unsigned HALF         = (CLKS_PER_BIT - 1) / 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic              rx_s;
  logic              rx_prev_q;
  uart_state_t       state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              stop_sample;
  logic              stop_ok;

  uart_sync2 u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        // Only a 1->0 transition starts a frame; a line stuck low is ignored.
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (baud_cnt_q == CNT_HALF) begin
          baud_cnt_d = '0;
          if (!rx_s) begin
            bit_idx_d = '0;
            state_d   = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (baud_cnt_q == CNT_LAST) begin
          baud_cnt_d = '0;
          shreg_d    = {rx_s, shreg_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_cnt_q == CNT_LAST) begin
          baud_cnt_d = '0;
          par_bad_d  = (rx_s != even_parity(shreg_q));
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
        if (baud_cnt_q == CNT_LAST) begin
          baud_cnt_d  = '0;
          stop_sample = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        baud_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign stop_ok = rx_s && !par_bad_q;
`else
  assign stop_ok = rx_s;
`endif

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
`endif

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    if (stop_sample) begin
      if (!rx_s) begin
        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      end else if (par_bad_q) begin
        perr_d = 1'b1;
`endif
      end else if (stop_ok && (!valid_q || rx_ready)) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        // Holding register still owned by the consumer: keep the old byte.
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != ST_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against uart_rx; expectations come from a
// frame-level model (good frame -> byte, bad stop -> frame_err, full -> overrun).
module tb_uart_rx;

  localparam int unsigned FREQ = 12000000;
  localparam int unsigned BAUD = 115200;
  localparam int unsigned CPB  = FREQ / BAUD;
  localparam int unsigned HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  // 2 synchronizer clocks, detection on the 3rd, then HALF + bits to the stop sample, +1 to register.
  localparam int unsigned LATENCY = 3 + HALF + (9 + PAR_BITS) * CPB + 1;

  logic       clk = 1'b0;
  logic       nrst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int tests = 0;
  int fails = 0;

  uart_rx #(.FREQ(FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Monitor: the only writer of these observation variables.
  int          cyc = 0;
  logic [7:0]  got_mem [0:255];
  int          got_wr = 0;
  int          valid_cyc = 0;
  int          valid_rise_cyc = 0;
  int          ferr_cyc = 0;
  int          ovr_cyc = 0;
  int          perr_cyc = 0;
  logic        valid_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nrst) begin
      if (rx_valid && !valid_seen) valid_rise_cyc = cyc;
      valid_seen = rx_valid;
      if (rx_valid) valid_cyc = valid_cyc + 1;
      if (frame_err) ferr_cyc = ferr_cyc + 1;
      if (overrun) ovr_cyc = ovr_cyc + 1;
      if (parity_err) perr_cyc = perr_cyc + 1;
      if (rx_valid && rx_ready) begin
        got_mem[got_wr[7:0]] = rx_data;
        got_wr = got_wr + 1;
        $display("[TB] cycle %0d: byte 0x%02h accepted", cyc, rx_data);
      end
    end else begin
      valid_seen = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rd_idx = 0;
  int start_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // rx_ready changes between posedge and negedge so the negedge monitor sees the
  // value that the next posedge will use.
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_ok);
    start_cyc = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_ok ? (^b) : ~(^b);
    tick(CPB);
`endif
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    $display("[TB] cycle %0d: sent 0x%02h stop=%0b par_ok=%0b", cyc, b, stop_bit, par_ok);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    for (int k = 0; k < 4 * CPB && got_wr <= rd_idx; k++) tick(1);
    if (got_wr > rd_idx) begin
      chk(tag, {24'd0, got_mem[rd_idx[7:0]]}, {24'd0, exp});
      rd_idx++;
    end else begin
      chk({tag, "_timeout"}, got_wr, rd_idx + 1);
    end
  endtask

  int base_ferr, base_ovr, base_perr, base_wr, base_vcyc;
  logic [7:0] rb;
  logic       bad;

  initial begin
    nrst     = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    tick(5);
    chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_busy", rx_busy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_parity_err", parity_err, 0);
    nrst = 1'b1;
    tick(CPB);

    // Single frame 0x61: latency, exactly one valid cycle, no flags.
    base_ferr = ferr_cyc; base_ovr = ovr_cyc; base_perr = perr_cyc; base_vcyc = valid_cyc;
    send_frame(8'h61, 1'b1, 1'b1);
    expect_byte("single_0x61", 8'h61);
    chk("single_latency", valid_rise_cyc - start_cyc, LATENCY);
    chk("single_valid_cycles", valid_cyc - base_vcyc, 1);
    chk("single_no_flags", (ferr_cyc - base_ferr) + (ovr_cyc - base_ovr) + (perr_cyc - base_perr), 0);
    chk("single_busy_low", rx_busy, 0);

    // Back-to-back frames with no idle gap.
    base_ovr = ovr_cyc;
    send_frame(8'h6E, 1'b1, 1'b1);
    send_frame(8'h53, 1'b1, 1'b1);
    send_frame(8'h70, 1'b1, 1'b1);
    expect_byte("b2b_0", 8'h6E);
    expect_byte("b2b_1", 8'h53);
    expect_byte("b2b_2", 8'h70);
    chk("b2b_no_overrun", ovr_cyc - base_ovr, 0);
    tick(CPB);

    // Short low glitch: START aborts at mid-bit.
    base_wr = got_wr; base_ferr = ferr_cyc; base_ovr = ovr_cyc; base_perr = perr_cyc;
    rx = 1'b0;
    tick(5);
    chk("glitch_busy_high", rx_busy, 1);
    tick(HALF / 2 - 5);
    rx = 1'b1;
    tick(CPB);
    chk("glitch_busy_low", rx_busy, 0);
    chk("glitch_no_valid", got_wr - base_wr, 0);
    chk("glitch_no_flags", (ferr_cyc - base_ferr) + (ovr_cyc - base_ovr) + (perr_cyc - base_perr), 0);

    // Stop bit low: one-clock frame_err, byte discarded, then recovery.
    base_wr = got_wr; base_ferr = ferr_cyc;
    send_frame(8'h61, 1'b0, 1'b1);
    tick(2 * CPB);
    chk("ferr_pulse_cycles", ferr_cyc - base_ferr, 1);
    chk("ferr_no_valid", got_wr - base_wr, 0);
    chk("ferr_valid_low", rx_valid, 0);
    send_frame(8'h53, 1'b1, 1'b1);
    expect_byte("ferr_recover_0x53", 8'h53);

    // Overrun: consumer not ready, second byte dropped.
    set_ready(1'b0);
    base_ovr = ovr_cyc;
    send_frame(8'h61, 1'b1, 1'b1);
    chk("ovr_first_valid", rx_valid, 1);
    send_frame(8'h53, 1'b1, 1'b1);
    chk("ovr_pulse_cycles", ovr_cyc - base_ovr, 1);
    chk("ovr_data_kept", {24'd0, rx_data}, 32'h61);
    chk("ovr_valid_held", rx_valid, 1);
    set_ready(1'b1);
    tick(1);
    chk("ovr_valid_cleared", rx_valid, 0);
    expect_byte("ovr_consumed_0x61", 8'h61);
    chk("ovr_no_second", got_wr, rd_idx);

`ifdef UART_RX_PARITY_EN
    base_wr = got_wr; base_perr = perr_cyc;
    send_frame(8'h61, 1'b1, 1'b0);
    tick(CPB);
    chk("perr_pulse_cycles", perr_cyc - base_perr, 1);
    chk("perr_no_valid", got_wr - base_wr, 0);
`endif

    // Randomized frames checked against the frame-level model.
    for (int n = 0; n < 8; n++) begin
      rb  = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      base_wr = got_wr; base_ferr = ferr_cyc;
      send_frame(rb, ~bad, 1'b1);
      if (bad) begin
        tick(2 * CPB);
        chk($sformatf("rand%0d_ferr", n), ferr_cyc - base_ferr, 1);
        chk($sformatf("rand%0d_dropped", n), got_wr - base_wr, 0);
      end else begin
        expect_byte($sformatf("rand%0d_byte", n), rb);
        chk($sformatf("rand%0d_no_ferr", n), ferr_cyc - base_ferr, 0);
      end
    end

    // Reset mid-data discards the pending holding-register byte and the partial frame.
    set_ready(1'b0);
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("rst_pending_valid", rx_valid, 1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    chk("rst_midframe_busy", rx_busy, 1);
    nrst = 1'b0;
    tick(2);
    chk("rst_valid_cleared", rx_valid, 0);
    chk("rst_data_cleared", {24'd0, rx_data}, 32'h00);
    chk("rst_busy_cleared", rx_busy, 0);
    rx_ready = 1'b1;
    nrst = 1'b1;
    tick(2 * CPB);
    base_wr = got_wr;
    send_frame(8'h70, 1'b1, 1'b1);
    expect_byte("rst_after_0x70", 8'h70);
    chk("rst_after_count", got_wr - base_wr, 1);

`ifndef UART_RX_PARITY_EN
    chk("parity_err_never", perr_cyc, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
